// File: rtl/ky032_duty_scheduler.sv
// KY-032 obstacle sensor duty-cycle scheduler.
// Cycles the sensor EN pin through cool-down (OFF), settle and sample windows,
// debounces the sampled output into a detect level and counts new obstacles.
// Optional build macro: KY032_THERMAL_GUARD_EN adds force_on/thermal_trip and a
// continuous on-time limit of MAX_ON_CYCLES.
module ky032_duty_scheduler #(
   parameter int unsigned OFF_CYCLES    = 1000,
   parameter int unsigned SETTLE_CYCLES = 200,
   parameter int unsigned ON_CYCLES     = 2000,
   parameter int unsigned DEBOUNCE      = 4,
`ifdef KY032_THERMAL_GUARD_EN
   parameter int unsigned MAX_ON_CYCLES = 100000,
`endif
   parameter int unsigned CNT_W         = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             sensor_out,
   input  logic             count_clr,
`ifdef KY032_THERMAL_GUARD_EN
   input  logic             force_on,
   output logic             thermal_trip,
`endif
   output logic             sensor_en,
   output logic             active,
   output logic             detect,
   output logic             detect_pulse,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned TMR_MAX0 = (OFF_CYCLES > SETTLE_CYCLES) ? OFF_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TMR_MAX  = (TMR_MAX0 > ON_CYCLES) ? TMR_MAX0 : ON_CYCLES;
   localparam int unsigned TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int unsigned DB_W     = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2
   } state_t;

   state_t             state_q;
   logic [TMR_W-1:0]   timer_q;
   logic               sensor_en_q;
   logic               active_q;
   logic               sync1_q;
   logic               sync2_q;
   logic [DB_W-1:0]    db_cnt_q,  db_cnt_d;
   logic               detect_q,  detect_d;
   logic               pulse_q,   pulse_d;
   logic [CNT_W-1:0]   count_q,   count_d;

   logic               obs;
   logic               force_eff;
   logic               on_limit;
   logic               off_done;
   logic               settle_done;
   logic               on_last;
   logic               leave_sample;

   // Pin level after synchronisation, active-high obstacle
   assign obs = ~sync2_q;

`ifdef KY032_THERMAL_GUARD_EN
   localparam int unsigned ON_W = (MAX_ON_CYCLES > 1) ? $clog2(MAX_ON_CYCLES) : 1;

   logic [ON_W-1:0] on_cnt_q;
   logic            trip_q;
   logic            force_lock_q;

   assign force_eff = force_on & ~force_lock_q;
   assign on_limit  = (state_q != ST_OFF) && (on_cnt_q == ON_W'(MAX_ON_CYCLES - 1));

   // On-time counter, trip pulse and post-trip force lockout
   always_ff @(posedge clk) begin
      if (rst) begin
         on_cnt_q     <= '0;
         trip_q       <= 1'b0;
         force_lock_q <= 1'b0;
      end else begin
         if (state_q == ST_OFF) on_cnt_q <= '0;
         else                   on_cnt_q <= on_cnt_q + ON_W'(1);
         trip_q <= run & on_limit;
         if (run && on_limit) force_lock_q <= 1'b1;
         else if (!force_on)  force_lock_q <= 1'b0;
      end
   end

   assign thermal_trip = trip_q;
`else
   assign force_eff = 1'b0;
   assign on_limit  = 1'b0;
`endif

   // Window-end decodes shared by the FSM and the debouncer
   always_comb begin
      off_done     = (timer_q == TMR_W'(OFF_CYCLES - 1));
      settle_done  = (timer_q == TMR_W'(SETTLE_CYCLES - 1));
      on_last      = (timer_q == TMR_W'(ON_CYCLES - 1));
      leave_sample = (state_q == ST_SAMPLE) && (!run || (on_last && !force_eff) || on_limit);
   end

   // Power sequencing FSM with registered EN/active outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_OFF;
         timer_q     <= '0;
         sensor_en_q <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (off_done) begin
                  if (run) begin
                     state_q     <= ST_SETTLE;
                     timer_q     <= '0;
                     sensor_en_q <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            ST_SETTLE: begin
               if (!run || on_limit) begin
                  state_q     <= ST_OFF;
                  timer_q     <= '0;
                  sensor_en_q <= 1'b0;
               end else if (settle_done) begin
                  state_q  <= ST_SAMPLE;
                  timer_q  <= '0;
                  active_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            ST_SAMPLE: begin
               if (leave_sample) begin
                  state_q     <= ST_OFF;
                  timer_q     <= '0;
                  sensor_en_q <= 1'b0;
                  active_q    <= 1'b0;
               end else if (!on_last) begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            default: begin
               state_q     <= ST_OFF;
               timer_q     <= '0;
               sensor_en_q <= 1'b0;
               active_q    <= 1'b0;
            end
         endcase
      end
   end

   // Two-flop synchroniser, idles at "no obstacle"
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= sensor_out;
         sync2_q <= sync1_q;
      end
   end

   // Debounce only while sampling; detect is held through OFF/SETTLE
   always_comb begin
      db_cnt_d = '0;
      detect_d = detect_q;
      if (state_q == ST_SAMPLE) begin
         if (obs != detect_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
               detect_d = obs;
               db_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         if (leave_sample) db_cnt_d = '0;
      end
      pulse_d = detect_d & ~detect_q;
      count_d = count_q;
      if (count_clr)    count_d = '0;
      else if (pulse_d) count_d = count_q + CNT_W'(1);
   end

   // Detect, pulse and item counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt_q <= '0;
         detect_q <= 1'b0;
         pulse_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         db_cnt_q <= db_cnt_d;
         detect_q <= detect_d;
         pulse_q  <= pulse_d;
         count_q  <= count_d;
      end
   end

   assign sensor_en    = sensor_en_q;
   assign active       = active_q;
   assign detect       = detect_q;
   assign detect_pulse = pulse_q;
   assign count        = count_q;

endmodule

// File: tb/tb_ky032_duty_scheduler.sv
// Directed bench for ky032_duty_scheduler (OFF=5, SETTLE=3, ON=8, DEBOUNCE=2).
// One schedule period is 16 edges; phase 0 is the first OFF cycle after reset.
module tb_ky032_duty_scheduler;

   localparam int unsigned CNT_W  = 6;
   localparam int unsigned PERIOD = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             run;
   logic             sensor_out;
   logic             count_clr;
   logic             force_on;
   logic             thermal_trip;
   logic             sensor_en;
   logic             active;
   logic             detect;
   logic             detect_pulse;
   logic [CNT_W-1:0] count;

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;

   always #5 clk = ~clk;

   ky032_duty_scheduler #(
      .OFF_CYCLES    (5),
      .SETTLE_CYCLES (3),
      .ON_CYCLES     (8),
      .DEBOUNCE      (2),
`ifdef KY032_THERMAL_GUARD_EN
      .MAX_ON_CYCLES (20),
`endif
      .CNT_W         (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .sensor_out   (sensor_out),
      .count_clr    (count_clr),
`ifdef KY032_THERMAL_GUARD_EN
      .force_on     (force_on),
      .thermal_trip (thermal_trip),
`endif
      .sensor_en    (sensor_en),
      .active       (active),
      .detect       (detect),
      .detect_pulse (detect_pulse),
      .count        (count)
   );

`ifndef KY032_THERMAL_GUARD_EN
   assign thermal_trip = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic goto_phase(input int p);
      while ((edge_n % PERIOD) != p) tick();
   endtask

   // One obstacle: present for a full period, then absent for a full period
   task automatic obstacle();
      goto_phase(0);
      sensor_out = 1'b0;
      tick();
      goto_phase(0);
      sensor_out = 1'b1;
      tick();
      goto_phase(0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_en"},     32'(sensor_en),    32'd0);
      chk({tag, "_active"}, 32'(active),       32'd0);
      chk({tag, "_detect"}, 32'(detect),       32'd0);
      chk({tag, "_pulse"},  32'(detect_pulse), 32'd0);
      chk({tag, "_count"},  32'(count),        32'd0);
      chk({tag, "_trip"},   32'(thermal_trip), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at edge %0d", edge_n);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; run = 1'b0; sensor_out = 1'b1; count_clr = 1'b0; force_on = 1'b0;
      tick();
      tick();
      chk_reset_outputs("reset");
      rst = 1'b0; run = 1'b1;
      edge_n = 0;

      // Two full periods of scheduling with no obstacle
      for (int e = 1; e <= 32; e++) begin
         int p;
         tick();
         p = edge_n % PERIOD;
         chk("sched_en",     32'(sensor_en), (p >= 5) ? 32'd1 : 32'd0);
         chk("sched_active", 32'(active),    (p >= 8) ? 32'd1 : 32'd0);
      end
      chk("idle_detect", 32'(detect), 32'd0);
      chk("idle_count",  32'(count),  32'd0);

      // Obstacle from mid-SAMPLE: detect four edges later
      goto_phase(10);
      sensor_out = 1'b0;
      repeat (3) tick();
      chk("lat_pre_detect", 32'(detect), 32'd0);
      tick();
      chk("lat_detect", 32'(detect),       32'd1);
      chk("lat_pulse",  32'(detect_pulse), 32'd1);
      chk("lat_count",  32'(count),        32'd1);
      tick();
      chk("lat_pulse_one", 32'(detect_pulse), 32'd0);
      repeat (32) tick();
      chk("held_detect", 32'(detect), 32'd1);
      chk("held_count",  32'(count),  32'd1);
      sensor_out = 1'b1;
      goto_phase(0);
      repeat (PERIOD) tick();
      chk("release_detect", 32'(detect), 32'd0);

      // Single-cycle glitches inside SAMPLE are rejected
      goto_phase(9);
      sensor_out = 1'b0; tick();
      sensor_out = 1'b1; tick();
      sensor_out = 1'b0; tick();
      sensor_out = 1'b1;
      goto_phase(0);
      chk("glitch_detect", 32'(detect), 32'd0);
      chk("glitch_count",  32'(count),  32'd1);

      // Obstacle only while OFF/SETTLE is not seen
      sensor_out = 1'b0;
      goto_phase(6);
      sensor_out = 1'b1;
      goto_phase(0);
      chk("offonly_detect", 32'(detect), 32'd0);
      chk("offonly_count",  32'(count),  32'd1);

      // Clear, count to all-ones, then wrap
      count_clr = 1'b1; tick(); count_clr = 1'b0;
      chk("clr_count", 32'(count), 32'd0);
      for (int i = 0; i < 63; i++) obstacle();
      chk("count_63", 32'(count), 32'd63);
      obstacle();
      chk("count_wrap", 32'(count), 32'd0);
      obstacle();
      chk("count_after_wrap", 32'(count), 32'd1);

      // Clear on the same edge as an increment: clear wins, pulse still fires
      goto_phase(0);
      sensor_out = 1'b0;
      goto_phase(9);
      count_clr = 1'b1;
      tick();
      chk("clrinc_pulse",  32'(detect_pulse), 32'd1);
      chk("clrinc_detect", 32'(detect),       32'd1);
      chk("clrinc_count",  32'(count),        32'd0);
      count_clr = 1'b0;
      tick();
      chk("clrinc_count_hold", 32'(count), 32'd0);
      sensor_out = 1'b1;
      goto_phase(0);
      tick();
      goto_phase(0);
      obstacle();
      chk("pre_run_count", 32'(count), 32'd1);

      // run dropped mid-SAMPLE, re-raised at once: full cool-down
      goto_phase(12);
      run = 1'b0;
      tick();
      chk("rundrop_en",     32'(sensor_en), 32'd0);
      chk("rundrop_active", 32'(active),    32'd0);
      run = 1'b1;
      repeat (4) tick();
      chk("rerun_off_en", 32'(sensor_en), 32'd0);
      tick();
      chk("rerun_settle_en",     32'(sensor_en), 32'd1);
      chk("rerun_settle_active", 32'(active),    32'd0);
      tick();

      // Reset mid-SETTLE
      rst = 1'b1;
      tick();
      chk_reset_outputs("midrst");
      rst = 1'b0;

`ifdef KY032_THERMAL_GUARD_EN
      // Forced window trips after 20 on-cycles, lockout until force_on toggles
      rst = 1'b1; force_on = 1'b1; run = 1'b1; sensor_out = 1'b1;
      tick();
      rst = 1'b0;
      edge_n = 0;
      repeat (4) tick();
      chk("tg_off_en", 32'(sensor_en), 32'd0);
      tick();
      chk("tg_on_en", 32'(sensor_en), 32'd1);
      repeat (19) tick();
      chk("tg_last_en",   32'(sensor_en),    32'd1);
      chk("tg_last_trip", 32'(thermal_trip), 32'd0);
      tick();
      chk("tg_trip_en", 32'(sensor_en),    32'd0);
      chk("tg_trip",    32'(thermal_trip), 32'd1);
      tick();
      chk("tg_trip_one", 32'(thermal_trip), 32'd0);
      while (edge_n < 41) tick();
      chk("tg_locked_active", 32'(active), 32'd0);
      force_on = 1'b0; tick();
      force_on = 1'b1;
      while (edge_n < 57) tick();
      chk("tg_forced_active", 32'(active), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ky032_duty_scheduler.md
Name: ky032_duty_scheduler

Overview:
- Duty-cycles the KY-032 obstacle sensor's EN pin to prevent overheating.
- Sequence: sensor off (cool-down), then powered with output ignored (settle), then powered with output sampled (sample).
- Samples are debounced into a stable detect level; each not-detecting -> detecting transition increments an item counter.
- Sits between the sensor pins and the production-line counting/LED logic.

Parameters:
OFF_CYCLES, 1000, cycles per cool-down period with EN low (>=1)
SETTLE_CYCLES, 200, cycles after EN rises during which the sensor output is ignored (>=1)
ON_CYCLES, 2000, cycles per sample window (>=1)
DEBOUNCE, 4, consecutive disagreeing samples needed to flip detect (>=1)
CNT_W, 6, item counter width
MAX_ON_CYCLES, 100000, continuous on-time limit (KY032_THERMAL_GUARD_EN only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
run  in  1  1 = scheduling enabled; 0 = sensor held off
sensor_out  in  1  raw sensor output, asynchronous, active-low (0 = obstacle)
count_clr  in  1  synchronous clear of count
sensor_en  out  1  drives sensor EN pin; 1 = powered
active  out  1  1 while in SAMPLE
detect  out  1  debounced obstacle level, 1 = obstacle
detect_pulse  out  1  one-cycle pulse on detect 0->1
count  out  CNT_W  items counted, wraps modulo 2^CNT_W

Behaviour:
- Reset: state=OFF, timer=0, debounce counter=0; sensor_en=0, active=0, detect=0, detect_pulse=0, count=0. The 2-FF synchronizer is reset to 1 (not detecting).
- sensor_out passes through a 2-FF synchronizer; obs = ~synced value.
- FSM (all outputs registered; sensor_en=1 in SETTLE and SAMPLE; active=1 in SAMPLE only):
  - OFF: timer counts 0..OFF_CYCLES-1. At OFF_CYCLES-1 with run=1 -> SETTLE, timer=0. With run=0, timer saturates at OFF_CYCLES-1 and the FSM waits; run rising then moves to SETTLE on the next edge.
  - SETTLE: SETTLE_CYCLES cycles, samples discarded, debounce counter held at 0 -> SAMPLE.
  - SAMPLE: ON_CYCLES cycles -> OFF, timer=0.
  - run=0 in SETTLE/SAMPLE -> OFF next edge, timer=0 (cool-down restarts in full).
- Debounce, evaluated only in SAMPLE:
  - obs != detect: counter increments.
  - obs == detect: counter clears to 0.
  - Counter reaches DEBOUNCE: detect <= obs, counter clears.
  - Counter is cleared on any exit from SAMPLE.
- Latency: with a pin level held stable throughout SAMPLE, detect changes DEBOUNCE+2 edges after the change.
- detect is retained across OFF/SETTLE, so an item present across a power cycle is counted once only.
- detect 0->1: detect_pulse=1 for exactly one cycle (same edge detect rises) and count <= count+1. At all-ones, count wraps to 0.
- count_clr: count <= 0. If simultaneous with an increment, clear wins (count=0); detect_pulse still fires.
- rst mid-window: all state returns to reset values on the next edge; sensor_en drops immediately that edge.

Optional Feature:
- KY032_THERMAL_GUARD_EN defined:
  - Adds input force_on (1 bit) and output thermal_trip (1 bit, reset 0).
  - force_on=1 in SAMPLE: window does not end at ON_CYCLES.
  - An on-time counter counts cycles since entering SETTLE. When it reaches MAX_ON_CYCLES -> OFF regardless of force_on, and thermal_trip=1 for one cycle.
  - After a trip, force_on is ignored until it is seen low for at least one cycle.
- Undefined: no force_on/thermal_trip ports; SAMPLE always ends after ON_CYCLES.

Test Plan (OFF=5, SETTLE=3, ON=8, DEBOUNCE=2, CNT_W=6 unless stated):
- rst, then run=1, sensor_out=1 held -> sensor_en rises after 5 cycles; active high for exactly 8 cycles after 3 settle cycles; period repeats every 16 cycles; detect=0, count=0.
- sensor_out=0 from mid-SAMPLE, held -> detect=1 four edges later, one detect_pulse, count=1; held low across next OFF/SETTLE/SAMPLE -> count stays 1.
- sensor_out 1-cycle low glitches in SAMPLE -> detect stays 0, count 0; obstacle present only during OFF/SETTLE -> count unchanged.
- count preloaded to 63 by 63 obstacles, one more obstacle -> count=0; count_clr asserted on the same edge as an increment -> count=0.
- run dropped mid-SAMPLE -> sensor_en=0 next edge; run re-raised -> full 5-cycle OFF before SETTLE. rst mid-SETTLE -> all outputs at reset values.
- KY032_THERMAL_GUARD_EN, MAX_ON_CYCLES=20, force_on=1 -> sensor_en high 20 cycles, thermal_trip pulse, OFF; no restart-forced window until force_on toggles low then high.
